// File: rtl/dlfloat_mac_stream.sv
// dlfloat_mac_stream: streaming DLFloat16 multiply-accumulate engine.
// Operand beats in over valid/ready, result framed out as two bytes.
module dlfloat_mac_stream #(
  parameter int IN_W    = 16,
  parameter int ACC_LEN = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_data,
  output logic            in_ready,
  input  logic            clear,
  output logic            out_valid,
  output logic [7:0]      out_byte,
  output logic            out_last
);

  typedef enum logic [2:0] {
    LOAD_A, LOAD_B, MUL, ACC, SEND_HI, SEND_LO
  } state_t;

  localparam logic        NARROW = (IN_W == 8);
  localparam logic [7:0]  LEN    = 8'(ACC_LEN);
  localparam logic [15:0] NAN    = 16'hFFFF;

  state_t      state;
  logic [15:0] opa, opb, prod, acc, result;
  logic [7:0]  cnt, cnt_nx;
  logic [7:0]  part;
  logic        half;
  logic [15:0] din16, word;
  logic        beat_done;

  // exponent range handling shared by multiply and add
  function automatic logic [15:0] sat_pack(
    input logic              s,
    input logic signed [7:0] e,
    input logic [8:0]        m
  );
    if (e > 8'sd62)
      sat_pack = {s, 6'h3F, 9'h1FE};
    else if (e < 8'sd1)
      sat_pack = 16'h0000;
    else
      sat_pack = {s, e[5:0], m};
  endfunction

  // narrow bus: first beat is the high byte, held in part
  assign din16     = 16'(in_data);
  assign word      = NARROW ? {part, din16[7:0]} : din16;
  assign beat_done = !NARROW || half;
  assign cnt_nx    = cnt + 8'd1;

  logic [19:0]       mp;
  logic signed [7:0] me;
  logic [8:0]        mm;
  logic [15:0]       mul_res;
  logic              unused_bits;

  assign unused_bits = ^mp[8:0];

  // truncating multiply of the two latched operands
  always_comb begin
    mp = 20'({1'b1, opa[8:0]}) * 20'({1'b1, opb[8:0]});
    me = $signed({2'b00, opa[14:9]})
       + $signed({2'b00, opb[14:9]}) - 8'sd31;
    mm = mp[17:9];
    if (mp[19]) begin
      mm = mp[18:10];
      me = me + 8'sd1;
    end
    if (opa == NAN || opb == NAN)
      mul_res = NAN;
    else if (opa == 16'h0 || opb == 16'h0)
      mul_res = 16'h0000;
    else
      mul_res = sat_pack(opa[15] ^ opb[15], me, mm);
  end

  logic [15:0]       big, sml;
  logic [5:0]        ed;
  logic [9:0]        mb, ms, adif;
  logic [10:0]       asum;
  logic [3:0]        lz;
  logic signed [7:0] ae;
  logic [8:0]        am;
  logic [15:0]       add_res;

  // aligned add/subtract of product into accumulator
  always_comb begin
    if (acc[14:0] >= prod[14:0]) begin
      big = acc;
      sml = prod;
    end else begin
      big = prod;
      sml = acc;
    end
    ed   = big[14:9] - sml[14:9];
    mb   = {1'b1, big[8:0]};
    ms   = (ed > 6'd10) ? 10'd0
         : ({1'b1, sml[8:0]} >> ed);
    asum = {1'b0, mb} + {1'b0, ms};
    adif = mb - ms;
    ae   = $signed({2'b00, big[14:9]});
    am   = asum[8:0];
    lz   = 4'd0;
    if (big[15] == sml[15]) begin
      if (asum[10]) begin
        am = asum[9:1];
        ae = ae + 8'sd1;
      end
    end else begin
      for (int i = 0; i < 10; i++)
        if (adif[i]) lz = 4'(9 - i);
      am = 9'(adif << lz);
      ae = ae - $signed({4'b0000, lz});
    end
    if (acc == NAN || prod == NAN)
      add_res = NAN;
    else if (acc == 16'h0)
      add_res = prod;
    else if (prod == 16'h0)
      add_res = acc;
    else if (big[15] != sml[15] && adif == 10'd0)
      add_res = 16'h0000;
    else
      add_res = sat_pack(big[15], ae, am);
  end

  // control FSM with operand, accumulator and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= LOAD_A;
      opa    <= 16'h0;
      opb    <= 16'h0;
      prod   <= 16'h0;
      acc    <= 16'h0;
      cnt    <= 8'd0;
      result <= 16'h0;
      part   <= 8'h0;
      half   <= 1'b0;
    end else if (clear) begin
      state <= LOAD_A;
      acc   <= 16'h0;
      cnt   <= 8'd0;
      half  <= 1'b0;
    end else begin
      unique case (state)
        LOAD_A, LOAD_B: begin
          if (in_valid) begin
            if (!beat_done) begin
              part <= din16[7:0];
              half <= 1'b1;
            end else begin
              half <= 1'b0;
              if (state == LOAD_A) begin
                opa   <= word;
                state <= LOAD_B;
              end else begin
                opb   <= word;
                state <= MUL;
              end
            end
          end
        end
        MUL: begin
          prod  <= mul_res;
          state <= ACC;
        end
        ACC: begin
          acc <= add_res;
          cnt <= cnt_nx;
          if (cnt_nx == LEN) begin
            result <= add_res;
            state  <= SEND_HI;
          end else begin
            state <= LOAD_A;
          end
        end
        SEND_HI: state <= SEND_LO;
        SEND_LO: begin
          acc   <= 16'h0;
          cnt   <= 8'd0;
          state <= LOAD_A;
        end
        default: state <= LOAD_A;
      endcase
    end
  end

  assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign out_valid = (state == SEND_HI) || (state == SEND_LO);
  assign out_last  = (state == SEND_LO);

  // result byte select for the output frame
  always_comb begin
    out_byte = 8'h00;
    unique case (1'b1)
      state == SEND_HI: out_byte = result[15:8];
      state == SEND_LO: out_byte = result[7:0];
      default: ;
    endcase
  end

endmodule
